// File: rtl/axi_slice_pkg.sv
// axi_slice_pkg: shared AXI R-beat type, response encodings and beat width helper
package axi_slice_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam int R_ID_W   = 4;
  localparam int R_DATA_W = 64;
  localparam int R_USER_W = 6;
  typedef struct packed {
    logic [R_ID_W-1:0]   id;
    logic [R_USER_W-1:0] user;
    logic [R_DATA_W-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } r_beat_t;
  // Flat beat width for any field sizing; bit order matches r_beat_t.
  function automatic int r_beat_bits(input int id_w, input int data_w, input int user_w);
    return id_w + user_w + data_w + 3;
  endfunction
endpackage

// File: rtl/axi_fifo_ram.sv
// axi_fifo_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, not reset
module axi_fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) r_mem[waddr_i] <= wdata_i;
  assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/axi_r_burst_buffer.sv
// axi_r_burst_buffer: AXI R-channel beat FIFO, cut-through or burst store-and-forward
module axi_r_burst_buffer
  import axi_slice_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int USER_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 8,
  parameter int STORE_FWD    = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            slave_valid_i,
  input  logic [DATA_WIDTH-1:0]           slave_data_i,
  input  logic [1:0]                      slave_resp_i,
  input  logic [USER_WIDTH-1:0]           slave_user_i,
  input  logic [ID_WIDTH-1:0]             slave_id_i,
  input  logic                            slave_last_i,
  output logic                            slave_ready_o,
  output logic                            master_valid_o,
  output logic [DATA_WIDTH-1:0]           master_data_o,
  output logic [1:0]                      master_resp_o,
  output logic [USER_WIDTH-1:0]           master_user_o,
  output logic [ID_WIDTH-1:0]             master_id_o,
  output logic                            master_last_o,
  input  logic                            master_ready_i,
  output logic [$clog2(BUFFER_DEPTH):0]   level_o,
  output logic [$clog2(BUFFER_DEPTH):0]   bursts_o
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = r_beat_bits(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
  localparam logic [LW-1:0] FULL = LW'(BUFFER_DEPTH);
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level, r_bursts;
  logic          w_push, w_pop, w_release;
  logic [BW-1:0] w_rdata;
  assign slave_ready_o  = (r_level < FULL) && !rst_i;
  // A full buffer releases regardless of bursts so over-long bursts cannot deadlock.
  assign w_release      = (STORE_FWD == 0) || (r_bursts != '0) || (r_level == FULL);
  assign master_valid_o = (r_level != '0) && w_release && !rst_i;
  assign w_push         = slave_valid_i && slave_ready_o;
  assign w_pop          = master_valid_o && master_ready_i;
  assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = w_rdata;
  assign level_o        = r_level;
  assign bursts_o       = r_bursts;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_bursts <= '0;
    end else begin
      r_wptr   <= r_wptr + AW'(w_push);
      r_rptr   <= r_rptr + AW'(w_pop);
      r_level  <= r_level + LW'(w_push) - LW'(w_pop);
      r_bursts <= r_bursts + LW'(w_push && slave_last_i) - LW'(w_pop && master_last_o);
    end
  axi_fifo_ram #(.DEPTH(BUFFER_DEPTH), .WIDTH(BW), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wptr),
    .wdata_i ({slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i}),
    .raddr_i (r_rptr),
    .rdata_o (w_rdata)
  );
endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// tb_axi_r_burst_buffer: directed scenarios plus randomized queue-model checking of both modes
module tb_axi_r_burst_buffer;
  import axi_slice_pkg::*;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_last, m_ready;
  logic [63:0] s_data;
  logic [1:0] s_resp;
  logic [5:0] s_user;
  logic [3:0] s_id;
  logic s_ready [2];
  logic m_valid [2];
  logic m_last [2];
  logic [63:0] m_data [2];
  logic [1:0] m_resp [2];
  logic [5:0] m_user [2];
  logic [3:0] m_id [2];
  logic [3:0] lvl [2];
  logic [3:0] bur [2];
  int tests = 0, fails = 0, sel = 0;

  typedef struct {
    logic [3:0] id; logic [5:0] user; logic [63:0] data; logic [1:0] resp; logic last;
  } beat_t;

  always #5 clk = ~clk;

  axi_r_burst_buffer #(.BUFFER_DEPTH(D), .STORE_FWD(0)) dut_ct (
    .clk_i(clk), .rst_i(rst), .slave_valid_i(s_valid), .slave_data_i(s_data),
    .slave_resp_i(s_resp), .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
    .slave_ready_o(s_ready[0]), .master_valid_o(m_valid[0]), .master_data_o(m_data[0]),
    .master_resp_o(m_resp[0]), .master_user_o(m_user[0]), .master_id_o(m_id[0]),
    .master_last_o(m_last[0]), .master_ready_i(m_ready), .level_o(lvl[0]), .bursts_o(bur[0]));

  axi_r_burst_buffer #(.BUFFER_DEPTH(D), .STORE_FWD(1)) dut_sf (
    .clk_i(clk), .rst_i(rst), .slave_valid_i(s_valid), .slave_data_i(s_data),
    .slave_resp_i(s_resp), .slave_user_i(s_user), .slave_id_i(s_id), .slave_last_i(s_last),
    .slave_ready_o(s_ready[1]), .master_valid_o(m_valid[1]), .master_data_o(m_data[1]),
    .master_resp_o(m_resp[1]), .master_user_o(m_user[1]), .master_id_o(m_id[1]),
    .master_last_o(m_last[1]), .master_ready_i(m_ready), .level_o(lvl[1]), .bursts_o(bur[1]));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] id, input logic [63:0] d, input logic l, input logic r);
    s_valid = v; s_id = id; s_data = d; s_last = l; m_ready = r;
    s_user = 6'(id) + 6'd1; s_resp = RESP_OKAY;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(0, 0, 0, 0, 0); tick(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(1, 0, 0, 0, 1); tick();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (s_ready[k] !== 1'b0 || m_valid[k] !== 1'b0) begin
        fails++; $display("FAIL reset_hold dut%0d ready=%b valid=%b required 0 0", k, s_ready[k], m_valid[k]);
      end
    end
    rst = 1'b0; drive(0, 0, 0, 0, 0); #1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({s_ready[k], m_valid[k], lvl[k], bur[k]} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
        fails++; $display("FAIL reset_release dut%0d ready=%b valid=%b level=%0d bursts=%0d required 1 0 0 0",
                          k, s_ready[k], m_valid[k], lvl[k], bur[k]);
      end
    end
  endtask

  task automatic test_single_beat();
    sel = 0; do_reset();
    drive(1, 4'd3, 64'hA5, 1, 0); s_resp = RESP_SLVERR;
    tests++;
    if (m_valid[0] !== 1'b0) begin fails++; $display("FAIL single_no_bypass valid=%b required 0", m_valid[0]); end
    tick(); drive(0, 0, 0, 0, 1);
    tests++;
    if ({m_valid[0], m_id[0], m_data[0], m_resp[0], m_user[0], m_last[0], lvl[0]} !==
        {1'b1, 4'd3, 64'hA5, RESP_SLVERR, 6'd4, 1'b1, 4'd1}) begin
      fails++; $display("FAIL single_out valid=%b id=%0d data=%h resp=%0d user=%0d last=%b level=%0d required 1 3 a5 2 4 1 1",
                        m_valid[0], m_id[0], m_data[0], m_resp[0], m_user[0], m_last[0], lvl[0]);
    end
    tick();
    tests++;
    if (lvl[0] !== 4'd0 || m_valid[0] !== 1'b0) begin
      fails++; $display("FAIL single_drain level=%0d valid=%b required 0 0", lvl[0], m_valid[0]);
    end
  endtask

  task automatic test_store_fwd();
    sel = 1; do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd1, 64'(i), i == 3, 1);
      tests++;
      if (m_valid[1] !== 1'b0) begin fails++; $display("FAIL sf_hold beat%0d valid=%b required 0", i, m_valid[1]); end
      tick();
    end
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({m_valid[1], m_data[1], bur[1], lvl[1]} !== {1'b1, 64'(i), 4'd1, 4'(4 - i)}) begin
        fails++; $display("FAIL sf_pop%0d valid=%b data=%0d bursts=%0d level=%0d required 1 %0d 1 %0d",
                          i, m_valid[1], m_data[1], bur[1], lvl[1], i, 4 - i);
      end
      tick();
    end
    tests++;
    if ({m_valid[1], bur[1], lvl[1]} !== {1'b0, 4'd0, 4'd0}) begin
      fails++; $display("FAIL sf_done valid=%b bursts=%0d level=%0d required 0 0 0", m_valid[1], bur[1], lvl[1]);
    end
  endtask

  task automatic test_forced_release();
    int sent = 0, got = 0, cyc = 0;
    bit saw_full = 0;
    sel = 1; do_reset();
    while (got < 12 && cyc < 200) begin
      drive(sent < 12, 4'd2, 64'(sent), sent == 11, 1);
      if (lvl[1] == 4'(D)) begin
        saw_full = 1;
        tests++;
        if (s_ready[1] !== 1'b0 || m_valid[1] !== 1'b1) begin
          fails++; $display("FAIL fr_full ready=%b valid=%b required 0 1", s_ready[1], m_valid[1]);
        end
      end
      if (m_valid[1] === 1'b1) begin
        tests++;
        if (m_data[1] !== 64'(got) || m_last[1] !== (got == 11)) begin
          fails++; $display("FAIL fr_order data=%0d last=%b required %0d %b", m_data[1], m_last[1], got, got == 11);
        end
        got++;
      end
      if (s_valid && s_ready[1] === 1'b1) sent++;
      tick(); cyc++;
    end
    tests++;
    if (got != 12 || !saw_full) begin
      fails++; $display("FAIL fr_complete beats=%0d full_seen=%0d required 12 1", got, saw_full);
    end
  endtask

  task automatic test_full_stall();
    sel = 0; do_reset();
    for (int i = 0; i < D; i++) begin drive(1, 4'd5, 64'(100 + i), i == D - 1, 0); tick(); end
    for (int c = 0; c < 5; c++) begin
      drive(1, 4'd6, 64'hDEAD, 0, 0);
      tests++;
      if ({s_ready[0], m_valid[0], m_data[0], lvl[0]} !== {1'b0, 1'b1, 64'd100, 4'd8}) begin
        fails++; $display("FAIL stall%0d ready=%b valid=%b data=%0d level=%0d required 0 1 100 8",
                          c, s_ready[0], m_valid[0], m_data[0], lvl[0]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 1); tick(); drive(0, 0, 0, 0, 0);
    tests++;
    if ({s_ready[0], m_data[0], lvl[0]} !== {1'b1, 64'd101, 4'd7}) begin
      fails++; $display("FAIL stall_pulse ready=%b data=%0d level=%0d required 1 101 7", s_ready[0], m_data[0], lvl[0]);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 4'd7, 64'(i), i == 2, 0); tick(); end
    rst = 1'b1; drive(0, 0, 0, 0, 1); tick(); rst = 1'b0; #1;
    tests++;
    if ({lvl[0], bur[0], m_valid[0]} !== {4'd0, 4'd0, 1'b0}) begin
      fails++; $display("FAIL mid_reset level=%0d bursts=%0d valid=%b required 0 0 0", lvl[0], bur[0], m_valid[0]);
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (m_valid[0] !== 1'b0) begin fails++; $display("FAIL mid_reset_stale cycle%0d valid=%b required 0", c, m_valid[0]); end
      tick();
    end
  endtask

  task automatic test_random(input int mode, input int n);
    beat_t q[$];
    beat_t nb, hd;
    int lasts = 0, left = 0, delivered = 0, cyc = 0;
    bit exp_ready, exp_valid;
    sel = mode; do_reset();
    while (delivered < n && cyc < 4 * n + 1000 && fails < 50) begin
      if (left == 0) left = $urandom_range(1, 12);
      nb.id = 4'($urandom); nb.user = 6'($urandom); nb.data = {$urandom, $urandom};
      nb.resp = 2'($urandom); nb.last = (left == 1);
      s_valid = $urandom_range(0, 3) != 0; m_ready = $urandom_range(0, 3) != 0;
      s_id = nb.id; s_user = nb.user; s_data = nb.data; s_resp = nb.resp; s_last = nb.last;
      #1;
      exp_ready = q.size() < D;
      exp_valid = q.size() > 0 && (mode == 0 || lasts > 0 || q.size() == D);
      tests++;
      if ({s_ready[sel], m_valid[sel], lvl[sel], bur[sel]} !== {exp_ready, exp_valid, 4'(q.size()), 4'(lasts)}) begin
        fails++; $display("FAIL rnd_m%0d_state cyc%0d ready=%b valid=%b level=%0d bursts=%0d required %b %b %0d %0d",
                          mode, cyc, s_ready[sel], m_valid[sel], lvl[sel], bur[sel], exp_ready, exp_valid, q.size(), lasts);
      end
      if (exp_valid) begin
        hd = q[0];
        tests++;
        if ({m_id[sel], m_user[sel], m_data[sel], m_resp[sel], m_last[sel]} !== {hd.id, hd.user, hd.data, hd.resp, hd.last}) begin
          fails++; $display("FAIL rnd_m%0d_beat cyc%0d id=%0d data=%h last=%b required %0d %h %b",
                            mode, cyc, m_id[sel], m_data[sel], m_last[sel], hd.id, hd.data, hd.last);
        end
        if (m_ready) begin
          void'(q.pop_front()); lasts -= int'(hd.last); delivered++;
        end
      end
      if (s_valid && exp_ready) begin
        q.push_back(nb); lasts += int'(nb.last); left--;
      end
      @(posedge clk); #1; cyc++;
    end
    tests++;
    if (delivered != n) begin fails++; $display("FAIL rnd_m%0d_delivered got=%0d required %0d", mode, delivered, n); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; drive(0, 0, 0, 0, 0);
    test_reset();
    test_single_beat();
    test_store_fwd();
    test_forced_release();
    test_full_stall();
    test_reset_mid();
    test_random(0, 5000);
    test_random(1, 5000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_r_burst_buffer.md
AXI_R_BURST_BUFFER -- requirements
Module: axi_r_burst_buffer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, R-channel ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, R-channel data width.
REQ-003 SHALL have parameter USER_WIDTH, default 6, R-channel user width.
REQ-004 SHALL have parameter BUFFER_DEPTH, default 8, number of beat entries; power of two, >= 2.
REQ-005 SHALL have parameter STORE_FWD, default 0: 0 = cut-through, 1 = burst store-and-forward.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-009 SHALL have port slave_valid_i, input, 1, upstream beat valid.
REQ-010 SHALL have ports slave_data_i/resp_i/user_i/id_i/last_i, input, DATA_WIDTH/2/USER_WIDTH/ID_WIDTH/1, upstream beat fields.
REQ-011 SHALL have port slave_ready_o, output, 1, buffer accepts a beat.
REQ-012 SHALL have ports master_valid_o, output, 1, and master_data_o/resp_o/user_o/id_o/last_o, output, same widths as the slave fields, downstream beat.
REQ-013 SHALL have port master_ready_i, input, 1, downstream accepts a beat.
REQ-014 SHALL have port level_o, output, $clog2(BUFFER_DEPTH)+1, current number of stored beats.
REQ-015 SHALL have port bursts_o, output, $clog2(BUFFER_DEPTH)+1, number of stored beats with last=1.

Function
REQ-016 A push SHALL occur when slave_valid_i && slave_ready_o; a pop SHALL occur when master_valid_o && master_ready_i.
REQ-017 slave_ready_o SHALL be (level < BUFFER_DEPTH) && !rst_i, with no combinational dependence on master_ready_i; no push when full, even with a simultaneous pop.
REQ-018 Beats SHALL leave in arrival order with all five fields unchanged.
REQ-019 The minimum latency from push to master_valid_o is 1 cycle; there is no combinational bypass.
REQ-020 Cut-through (STORE_FWD=0): master_valid_o SHALL equal (level > 0).
REQ-021 Store-forward (STORE_FWD=1): master_valid_o SHALL equal (level > 0) && (bursts > 0 || level == BUFFER_DEPTH).
REQ-022 The level == BUFFER_DEPTH term is a forced release; it prevents deadlock when a burst is longer than BUFFER_DEPTH.
REQ-023 Once asserted, master_valid_o SHALL stay high, with stable fields, until the pop completes.
REQ-024 level SHALL update by +1 on push-only, -1 on pop-only, and stay unchanged on simultaneous push and pop.
REQ-025 bursts SHALL be +1 on pushing a last beat, -1 on popping a last beat, and unchanged when both happen in one cycle.
REQ-026 Read and write pointers SHALL wrap modulo BUFFER_DEPTH.
REQ-027 A simultaneous push and pop when level == 1 SHALL present the new beat on the following cycle.

Reset
REQ-028 While rst_i is high at a clock edge: pointers, level and bursts SHALL clear to 0.
REQ-029 While rst_i is high: slave_ready_o = 0 and master_valid_o = 0.
REQ-030 Reset asserted mid-burst SHALL discard all stored beats; the storage array is not reset.
REQ-031 On the first cycle after reset deassertion: slave_ready_o = 1, master_valid_o = 0, level_o = 0, bursts_o = 0.

Structure
REQ-032 The shared package axi_slice_pkg SHALL hold the R-beat packed struct (id, user, data, resp, last) and the AXI resp encoding constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
REQ-033 Storage SHALL be one sub-module axi_fifo_ram: dual-port, BUFFER_DEPTH x beat width, one synchronous write port, one asynchronous read port.
REQ-034 Control (pointers, level, bursts, valid gating) SHALL reside in axi_r_burst_buffer.

Verification
REQ-035 Cut-through, DEPTH=8, one beat (id=3, data=0xA5, last=1) pushed at cycle 0 -> master_valid_o=1 at cycle 1 with identical fields; level_o 1 -> 0 after the pop.
REQ-036 STORE_FWD=1, 4-beat burst pushed one per cycle with master_ready_i=1 -> master_valid_o low until the cycle after beat 4 is pushed, then 4 consecutive pops; bursts_o goes 1 -> 0 on the last pop.
REQ-037 STORE_FWD=1, DEPTH=8, 12-beat burst -> slave_ready_o drops at level 8, forced release begins, and all 12 beats arrive in order without deadlock.
REQ-038 Full buffer with master_ready_i=0 for 5 cycles -> slave_ready_o=0 and outputs stable; a 1-cycle master_ready_i pulse -> level_o 8 -> 7 and slave_ready_o=1 on the next cycle.
REQ-039 rst_i asserted for 1 cycle with 3 beats stored -> next cycle level_o=0, bursts_o=0, master_valid_o=0, and no stale beat is ever emitted.
REQ-040 Random valid/ready, 10k beats, both modes -> scoreboard shows in-order, lossless delivery, and level_o/bursts_o match the model every cycle.
